sram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the DE2-115 on-board 1M x 16 asynchronous SRAM (SRAM_ADDR/DQ/CE_N/OE_N/WE_N/LB_N/UB_N). It sits between de2_115_top's SRAM pins and two internal requesters. It grants the SRAM round-robin and runs each access as a fixed four-cycle pin sequence at 50 MHz. It replaces the static "SRAM disabled" tie-offs in the top level.

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/sram_rr_arbiter.sv | 36 +++
 rtl/sram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port DE2-115 SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_PORTS       = 2;
  localparam int SRAM_ADDR_WIDTH = 20;
  localparam int SRAM_DATA_WIDTH = 16;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant with the last_grant history bit; grant is one-hot.
module sram_rr_arbiter
  import sram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] grant
);

  logic last_grant;

  // On a tie the port that did not win last time is favoured.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // History bit: reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (en && (|req)) begin
      last_grant <= grant[1];
    end else begin
      last_grant <= last_grant;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin two-port sequencer for the DE2-115 1M x 16 async SRAM; every
// access is a fixed IDLE->SETUP->ACCESS->DONE pin sequence with registered strobes.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [NUM_PORTS-1:0]  we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [1:0]            be0,
  input  logic [1:0]            be1,
  output logic [NUM_PORTS-1:0]  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  inout  wire  [DATA_WIDTH-1:0] SRAM_DQ,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_LB_N,
  output logic                  SRAM_UB_N
);

  state_t                state, state_nxt;
  logic                  cmd_we, we_nxt;
  logic [ADDR_WIDTH-1:0] cmd_addr, addr_nxt;
  logic [DATA_WIDTH-1:0] cmd_wdata, wdata_nxt;
  logic [1:0]            cmd_be, be_nxt;
  logic                  cmd_port, port_nxt;
  logic [NUM_PORTS-1:0]  grant;
  logic                  dq_oe, dq_oe_nxt;
  logic                  ce_nxt, oe_nxt, wen_nxt, lb_nxt, ub_nxt;
  logic [ADDR_WIDTH-1:0] sram_addr_nxt;
  logic [NUM_PORTS-1:0]  ack_nxt;

  sram_rr_arbiter u_rr (
    .clk   (CLOCK_50),
    .reset (RESET),
    .req   (req),
    .en    (state == IDLE),
    .grant (grant)
  );

  assign SRAM_DQ = dq_oe ? cmd_wdata : {DATA_WIDTH{1'bz}};

  // Next state and command capture; fields are only sampled in IDLE.
  always_comb begin
    state_nxt = state;
    we_nxt    = cmd_we;
    addr_nxt  = cmd_addr;
    wdata_nxt = cmd_wdata;
    be_nxt    = cmd_be;
    port_nxt  = cmd_port;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = SETUP;
          if (grant[1]) begin
            port_nxt = 1'b1; we_nxt = we[1]; addr_nxt = addr1; wdata_nxt = wdata1; be_nxt = be1;
          end else begin
            port_nxt = 1'b0; we_nxt = we[0]; addr_nxt = addr0; wdata_nxt = wdata0; be_nxt = be0;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin values are decoded from the upcoming state so they appear registered.
  always_comb begin
    sram_addr_nxt = SRAM_ADDR;
    ce_nxt        = 1'b1;
    oe_nxt        = 1'b1;
    wen_nxt       = 1'b1;
    lb_nxt        = 1'b1;
    ub_nxt        = 1'b1;
    dq_oe_nxt     = 1'b0;
    ack_nxt       = 2'b00;
    case (state_nxt)
      IDLE: begin
        ce_nxt = 1'b1;
      end
      SETUP, ACCESS, DONE: begin
        sram_addr_nxt = addr_nxt;
        ce_nxt        = 1'b0;
        if (we_nxt) begin
          lb_nxt    = ~be_nxt[0];
          ub_nxt    = ~be_nxt[1];
          dq_oe_nxt = 1'b1;
          wen_nxt   = (state_nxt == ACCESS) ? 1'b0 : 1'b1;
        end else begin
          lb_nxt = 1'b0;
          ub_nxt = 1'b0;
          oe_nxt = (state_nxt == DONE) ? 1'b1 : 1'b0;
        end
        if (state_nxt == DONE) begin
          ack_nxt = port_nxt ? 2'b10 : 2'b01;
        end else begin
          ack_nxt = 2'b00;
        end
      end
      default: begin
        ce_nxt = 1'b1;
      end
    endcase
  end

  // State, command and pin registers; read data is captured as ACCESS closes.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_addr  <= {ADDR_WIDTH{1'b0}};
      cmd_wdata <= {DATA_WIDTH{1'b0}};
      cmd_be    <= 2'b00;
      cmd_port  <= 1'b0;
      SRAM_ADDR <= {ADDR_WIDTH{1'b0}};
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      dq_oe     <= 1'b0;
      ack       <= 2'b00;
      busy      <= 1'b0;
      rdata     <= {DATA_WIDTH{1'b0}};
    end else begin
      state     <= state_nxt;
      cmd_we    <= we_nxt;
      cmd_addr  <= addr_nxt;
      cmd_wdata <= wdata_nxt;
      cmd_be    <= be_nxt;
      cmd_port  <= port_nxt;
      SRAM_ADDR <= sram_addr_nxt;
      SRAM_CE_N <= ce_nxt;
      SRAM_OE_N <= oe_nxt;
      SRAM_WE_N <= wen_nxt;
      SRAM_LB_N <= lb_nxt;
      SRAM_UB_N <= ub_nxt;
      dq_oe     <= dq_oe_nxt;
      ack       <= ack_nxt;
      busy      <= (state_nxt != IDLE);
      if ((state == ACCESS) && !cmd_we) begin
        rdata <= SRAM_DQ;
      end else begin
        rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a cycle-level async SRAM model on the pins.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [1:0]  req, we;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  be0, be1;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        busy;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:255];

  sram_arbiter dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .ack(ack), .rdata(rdata), .busy(busy),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_UB_N(SRAM_UB_N)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // SRAM model: byte-lane write while CE_N and WE_N are low, read drive while OE_N is low.
  always @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else if (SRAM_CE_N == 1'b0 && SRAM_WE_N == 1'b0) begin
      if (SRAM_LB_N == 1'b0) mem[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ[7:0];
      if (SRAM_UB_N == 1'b0) mem[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ[15:8];
    end
  end

  assign SRAM_DQ = (SRAM_CE_N == 1'b0 && SRAM_OE_N == 1'b0 && SRAM_WE_N == 1'b1)
                   ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request on port p; reports ack latency, WE_N-low cycles, lanes during WE_N low,
  // read data at ack and the address in the ACCESS cycle. Ends back in IDLE.
  task automatic run_op(input int p, input logic w, input logic [19:0] a,
                        input logic [15:0] d, input logic [1:0] b,
                        output int lat, output int we_low, output logic [1:0] lanes,
                        output logic [15:0] rd, output logic [19:0] a_seen);
    lat = 0; we_low = 0; lanes = 2'b11; rd = 16'h0000; a_seen = 20'h00000;
    if (p == 0) begin
      we[0] = w; addr0 = a; wdata0 = d; be0 = b;
    end else begin
      we[1] = w; addr1 = a; wdata1 = d; be1 = b;
    end
    req[p] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (SRAM_WE_N === 1'b0) begin
        we_low++;
        lanes = {SRAM_UB_N, SRAM_LB_N};
      end
      if (k == 2) a_seen = SRAM_ADDR;
      if (ack[p] === 1'b1) begin
        lat = k;
        rd  = rdata;
        break;
      end
    end
    req[p] = 1'b0;
    tick();
  endtask

  int          lat, we_low, n, seen;
  logic [1:0]  lanes;
  logic [15:0] rd;
  logic [19:0] a_seen;
  int          ack_cyc [4];
  logic [1:0]  ack_val [4];

  initial begin
    RESET = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = 20'h0; addr1 = 20'h0; wdata0 = 16'h0; wdata1 = 16'h0; be0 = 2'b00; be1 = 2'b00;
    tick();
    chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 32'h1F);
    chk("rst_ack_busy", {ack, busy}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", SRAM_ADDR, 32'h0);
    chk("rst_dq_z", dut.dq_oe, 32'h0);

    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_hold", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N, ack, busy, dut.dq_oe},
          {5'h1F, 2'b00, 1'b0, 1'b0});
    end

    run_op(0, 1'b1, 20'h00012, 16'hBEEF, 2'b11, lat, we_low, lanes, rd, a_seen);
    chk("wr_latency", lat, 32'd3);
    chk("wr_we_low_cycles", we_low, 32'd1);
    chk("wr_addr", a_seen, 32'h00012);
    chk("wr_after_idle", {ack, busy}, 32'h0);

    run_op(0, 1'b0, 20'h00012, 16'h0000, 2'b00, lat, we_low, lanes, rd, a_seen);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data", rd, 32'hBEEF);
    chk("rd_no_we", we_low, 32'd0);

    run_op(0, 1'b1, 20'h00040, 16'hAAAA, 2'b11, lat, we_low, lanes, rd, a_seen);
    run_op(0, 1'b1, 20'h00040, 16'h5555, 2'b01, lat, we_low, lanes, rd, a_seen);
    chk("lane_ub_lb", lanes, 32'h2);
    chk("lane_we_low", we_low, 32'd1);
    run_op(0, 1'b0, 20'h00040, 16'h0000, 2'b00, lat, we_low, lanes, rd, a_seen);
    chk("lane_rd", rd, 32'hAA55);

    run_op(1, 1'b1, 20'h00040, 16'h1234, 2'b00, lat, we_low, lanes, rd, a_seen);
    chk("be00_latency", lat, 32'd3);
    chk("be00_lanes", lanes, 32'h3);
    run_op(1, 1'b0, 20'h00040, 16'h0000, 2'b00, lat, we_low, lanes, rd, a_seen);
    chk("be00_rd", rd, 32'hAA55);

    run_op(1, 1'b1, 20'hFFFFF, 16'hC3C3, 2'b11, lat, we_low, lanes, rd, a_seen);
    chk("p1_hi_addr", a_seen, 32'hFFFFF);
    run_op(0, 1'b0, 20'hFFFFF, 16'h0000, 2'b00, lat, we_low, lanes, rd, a_seen);
    chk("p0_hi_rd", rd, 32'hC3C3);

    // Tie arbitration straight after reset.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    we = 2'b11;
    addr0 = 20'h00010; wdata0 = 16'h1111; be0 = 2'b11;
    addr1 = 20'h00020; wdata1 = 16'h2222; be1 = 2'b11;
    req = 2'b11;
    n = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (ack !== 2'b00) begin
        ack_cyc[n] = k;
        ack_val[n] = ack;
        n++;
        if (n == 4) begin
          req = 2'b00;
          break;
        end
      end
    end
    tick();
    chk("tie_ack_count", n, 32'd4);
    if (n == 4) begin
      chk("tie_first_lat", ack_cyc[0], 32'd3);
      chk("tie_g0", ack_val[0], 32'h1);
      chk("tie_g1", ack_val[1], 32'h2);
      chk("tie_g2", ack_val[2], 32'h1);
      chk("tie_g3", ack_val[3], 32'h2);
      for (int i = 1; i < 4; i++) chk("tie_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd4);
    end
    run_op(1, 1'b0, 20'h00010, 16'h0000, 2'b00, lat, we_low, lanes, rd, a_seen);
    chk("tie_rd_p0_data", rd, 32'h1111);
    run_op(0, 1'b0, 20'h00020, 16'h0000, 2'b00, lat, we_low, lanes, rd, a_seen);
    chk("tie_rd_p1_data", rd, 32'h2222);

    // Reset arriving during the ACCESS cycle of a write.
    we[0] = 1'b1; addr0 = 20'h00050; wdata0 = 16'h7777; be0 = 2'b11;
    req[0] = 1'b1;
    tick();
    chk("mid_setup_busy_dq", {busy, dut.dq_oe}, 32'h3);
    tick();
    chk("mid_access_we", SRAM_WE_N, 32'h0);
    RESET = 1'b1;
    req = 2'b00;
    tick();
    chk("mid_rst_pins", {SRAM_WE_N, dut.dq_oe, busy, ack}, {1'b1, 1'b0, 1'b0, 2'b00});
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    RESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack !== 2'b00) seen++;
    end
    chk("mid_rst_no_ack", seen, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
